// File: rtl/reg_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : reg_fifo_pkt
// Purpose  : Register-based synchronous FIFO with per-word packet-end tag.
//            Any depth 2..64 (power of two not required), runtime
//            almost-full / almost-empty thresholds, packet counting,
//            synchronous flush, sticky overflow / underflow flags and a
//            selectable first-word-fall-through or standard read mode.
//            Used as the small elastic buffer in front of AXI frame-buffer
//            burst logic.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   fwft_mode        "true"  : dout valid while empty_n=1 (read latency 0)
//                    "false" : dout loads the head word 1 cycle after a read
//   fifo_depth       number of entries, 2..64
//   fifo_data_width  data width in bits
//   simulation_delay simulation-only register update delay (not modelled in
//                    this synthesizable view; range-checked only)
//   CW               width of every count / threshold field
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   flush                  synchronous clear of contents and flags
//   fifo_wen/din/din_last  write request, data and packet-end tag
//   fifo_full(_n)          full flag and its inverse
//   fifo_almost_full       data_cnt >= almost_full_th
//   fifo_ren               read request
//   fifo_dout/dout_last    read data and its packet-end tag
//   fifo_empty(_n)         empty flag and its inverse
//   fifo_almost_empty      data_cnt <= almost_empty_th
//   almost_full_th/_empty_th runtime thresholds
//   data_cnt, pkt_cnt      stored words / stored words tagged last
//   pkt_avail              pkt_cnt != 0
//   overflow, underflow    sticky error flags, cleared by err_clr
// ============================================================================
module reg_fifo_pkt #(
  parameter           fwft_mode        = "true",
  parameter int       fifo_depth       = 8,
  parameter int       fifo_data_width  = 32,
  parameter int       simulation_delay = 1,
  localparam int      CW               = $clog2(fifo_depth + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fifo_wen,
  input  logic [fifo_data_width-1:0] fifo_din,
  input  logic                       fifo_din_last,
  output logic                       fifo_full,
  output logic                       fifo_full_n,
  output logic                       fifo_almost_full,
  input  logic                       fifo_ren,
  output logic [fifo_data_width-1:0] fifo_dout,
  output logic                       fifo_dout_last,
  output logic                       fifo_empty,
  output logic                       fifo_empty_n,
  output logic                       fifo_almost_empty,
  input  logic [CW-1:0]              almost_full_th,
  input  logic [CW-1:0]              almost_empty_th,
  output logic [CW-1:0]              data_cnt,
  output logic [CW-1:0]              pkt_cnt,
  output logic                       pkt_avail,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int            PW       = $clog2(fifo_depth);
  localparam bit            FWFT     = (fwft_mode == "true");
  localparam logic [PW-1:0] PTR_LAST = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(fifo_depth);

  // Elaboration-time guard against unsupported parameter sets.
  generate
    if (fifo_depth < 2 || fifo_depth > 64 || fifo_data_width < 1 ||
        simulation_delay < 0 || (!FWFT && fwft_mode != "false")) begin : g_bad_params
      $error("reg_fifo_pkt: unsupported parameter set");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage (not reset: contents are meaningless until written)
  // --------------------------------------------------------------------------
  logic [fifo_data_width-1:0] mem_data_q [fifo_depth];
  logic                       mem_last_q [fifo_depth];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              pkt_q, pkt_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       afull_q, afull_d;
  logic                       aempty_q, aempty_d;
  logic                       avail_q, avail_d;
  logic                       ovf_q, ovf_d;
  logic                       udf_q, udf_d;
  logic [fifo_data_width-1:0] dout_q, dout_d;
  logic                       dout_last_q, dout_last_d;

  logic                       wr_acc, rd_acc;
  logic [PW-1:0]              wptr_inc, rptr_inc;
  logic                       pkt_inc, pkt_dec;

  // Acceptance uses registered flags only, so ren never gates a write
  // combinationally. Flush blocks both requests.
  assign wr_acc   = fifo_wen & ~full_q  & ~flush;
  assign rd_acc   = fifo_ren & ~empty_q & ~flush;

  // Explicit wrap so that non-power-of-two depths work.
  assign wptr_inc = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
  assign rptr_inc = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);

  assign pkt_inc  = wr_acc & fifo_din_last;
  assign pkt_dec  = rd_acc & mem_last_q[rptr_q];

  // --------------------------------------------------------------------------
  // Pointers, counts and flags
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    pkt_d  = pkt_q;

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      pkt_d  = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_inc;
      if (rd_acc) rptr_d = rptr_inc;

      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase

      if (pkt_inc && !pkt_dec) begin
        pkt_d = pkt_q + CW'(1);
      end else if (!pkt_inc && pkt_dec) begin
        pkt_d = pkt_q - CW'(1);
      end
    end

    // Flags follow the next count and the live thresholds, so a threshold
    // change with no traffic shows up one cycle later.
    full_d   = (cnt_d == CNT_FULL);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= almost_full_th);
    aempty_d = (cnt_d <= almost_empty_th);
    avail_d  = (pkt_d != '0);
  end

  // --------------------------------------------------------------------------
  // Sticky errors: a new error event wins over err_clr in the same cycle.
  // A read on an empty FIFO paired with a write is the normal "write into
  // empty" case and is not counted as an underflow.
  // --------------------------------------------------------------------------
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_wen && full_q && !flush) ovf_d = 1'b1;
    if (fifo_ren && empty_q && !fifo_wen && !flush) udf_d = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Output data register
  // --------------------------------------------------------------------------
  generate
    if (FWFT) begin : g_fwft
      // dout always shows the head word while the FIFO is non-empty.
      always_comb begin
        dout_d      = dout_q;
        dout_last_d = dout_last_q;
        if (rd_acc) begin
          if (cnt_q > CW'(1)) begin
            dout_d      = mem_data_q[rptr_inc];
            dout_last_d = mem_last_q[rptr_inc];
          end else if (wr_acc) begin
            // Last stored word leaves while a new one arrives: bypass din.
            dout_d      = fifo_din;
            dout_last_d = fifo_din_last;
          end
        end else if (wr_acc && empty_q) begin
          dout_d      = fifo_din;
          dout_last_d = fifo_din_last;
        end
      end
    end else begin : g_std
      // dout loads the head word on the cycle after an accepted read.
      always_comb begin
        dout_d      = dout_q;
        dout_last_d = dout_last_q;
        if (rd_acc) begin
          dout_d      = mem_data_q[rptr_q];
          dout_last_d = mem_last_q[rptr_q];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_data_q[wptr_q] <= fifo_din;
      mem_last_q[wptr_q] <= fifo_din_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      pkt_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      avail_q     <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      dout_q      <= '0;
      dout_last_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      pkt_q       <= pkt_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      avail_q     <= avail_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      dout_q      <= dout_d;
      dout_last_q <= dout_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_full         = full_q;
  assign fifo_full_n       = ~full_q;
  assign fifo_almost_full  = afull_q;
  assign fifo_empty        = empty_q;
  assign fifo_empty_n      = ~empty_q;
  assign fifo_almost_empty = aempty_q;
  assign fifo_dout         = dout_q;
  assign fifo_dout_last    = dout_last_q;
  assign data_cnt          = cnt_q;
  assign pkt_cnt           = pkt_q;
  assign pkt_avail         = avail_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_fifo_pkt
// Purpose  : Directed self-checking bench for reg_fifo_pkt. Instance A is a
//            depth-5 FWFT FIFO, instance B a depth-8 standard-mode FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_fifo_pkt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- instance A: depth 5, FWFT ----------------
  logic       a_flush = 0, a_wen = 0, a_din_last = 0, a_ren = 0, a_err_clr = 0;
  logic [7:0] a_din = 0;
  logic [2:0] a_af_th = 3'd3, a_ae_th = 3'd1;
  logic       a_full, a_full_n, a_af, a_dout_last, a_empty, a_empty_n, a_ae;
  logic       a_avail, a_ovf, a_udf;
  logic [7:0] a_dout;
  logic [2:0] a_cnt, a_pkt;

  reg_fifo_pkt #(.fwft_mode("true"), .fifo_depth(5), .fifo_data_width(8),
                 .simulation_delay(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .fifo_wen(a_wen), .fifo_din(a_din), .fifo_din_last(a_din_last),
    .fifo_full(a_full), .fifo_full_n(a_full_n), .fifo_almost_full(a_af),
    .fifo_ren(a_ren), .fifo_dout(a_dout), .fifo_dout_last(a_dout_last),
    .fifo_empty(a_empty), .fifo_empty_n(a_empty_n), .fifo_almost_empty(a_ae),
    .almost_full_th(a_af_th), .almost_empty_th(a_ae_th),
    .data_cnt(a_cnt), .pkt_cnt(a_pkt), .pkt_avail(a_avail),
    .overflow(a_ovf), .underflow(a_udf), .err_clr(a_err_clr));

  // ---------------- instance B: depth 8, standard mode ----------------
  logic       b_flush = 0, b_wen = 0, b_din_last = 0, b_ren = 0, b_err_clr = 0;
  logic [7:0] b_din = 0;
  logic [3:0] b_af_th = 4'd6, b_ae_th = 4'd2;
  logic       b_full, b_full_n, b_af, b_dout_last, b_empty, b_empty_n, b_ae;
  logic       b_avail, b_ovf, b_udf;
  logic [7:0] b_dout;
  logic [3:0] b_cnt, b_pkt;

  reg_fifo_pkt #(.fwft_mode("false"), .fifo_depth(8), .fifo_data_width(8),
                 .simulation_delay(1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .fifo_wen(b_wen), .fifo_din(b_din), .fifo_din_last(b_din_last),
    .fifo_full(b_full), .fifo_full_n(b_full_n), .fifo_almost_full(b_af),
    .fifo_ren(b_ren), .fifo_dout(b_dout), .fifo_dout_last(b_dout_last),
    .fifo_empty(b_empty), .fifo_empty_n(b_empty_n), .fifo_almost_empty(b_ae),
    .almost_full_th(b_af_th), .almost_empty_th(b_ae_th),
    .data_cnt(b_cnt), .pkt_cnt(b_pkt), .pkt_avail(b_avail),
    .overflow(b_ovf), .underflow(b_udf), .err_clr(b_err_clr));

  // Advance one clock; inputs change and outputs are sampled 1 ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] d, input logic l);
    a_wen = 1'b1; a_din = d; a_din_last = l;
    tick();
    a_wen = 1'b0; a_din_last = 1'b0;
  endtask

  task automatic a_read();
    a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] d, input logic l);
    b_wen = 1'b1; b_din = d; b_din_last = l;
    tick();
    b_wen = 1'b0; b_din_last = 1'b0;
  endtask

  task automatic b_read();
    b_ren = 1'b1;
    tick();
    b_ren = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (a_empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got %b exp 1", a_empty); end
    n_assert++; if (a_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_empty_n got %b exp 0", a_empty_n); end
    n_assert++; if (a_full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %b exp 0", a_full); end
    n_assert++; if (a_full_n !== 1'b1)  begin n_fail++; $display("FAIL reset_full_n got %b exp 1", a_full_n); end
    n_assert++; if (a_ae !== 1'b1)      begin n_fail++; $display("FAIL reset_aempty got %b exp 1", a_ae); end
    n_assert++; if (a_af !== 1'b0)      begin n_fail++; $display("FAIL reset_afull got %b exp 0", a_af); end
    n_assert++; if (a_cnt !== 3'd0)     begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
    n_assert++; if (a_pkt !== 3'd0 || a_avail !== 1'b0) begin n_fail++; $display("FAIL reset_pkt got %0d/%b exp 0/0", a_pkt, a_avail); end
    n_assert++; if (a_ovf !== 1'b0 || a_udf !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b/%b exp 0/0", a_ovf, a_udf); end
    n_assert++; if (a_dout !== 8'h00 || a_dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %h/%b exp 00/0", a_dout, a_dout_last); end
    n_assert++; if (b_dout !== 8'h00 || b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b got %h/%b exp 00/1", b_dout, b_empty); end
    rst = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fill_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp = 8'((i + 1) * 8'h11);
      a_write(exp, 1'b0);
      if (i == 0) begin
        n_assert++; if (a_dout !== 8'h11 || a_empty_n !== 1'b1) begin n_fail++; $display("FAIL fwft_first got %h/%b exp 11/1", a_dout, a_empty_n); end
      end
    end
    n_assert++; if (a_full !== 1'b1 || a_full_n !== 1'b0) begin n_fail++; $display("FAIL fill_full got %b/%b exp 1/0", a_full, a_full_n); end
    n_assert++; if (a_cnt !== 3'd5 || a_af !== 1'b1)      begin n_fail++; $display("FAIL fill_cnt got %0d/%b exp 5/1", a_cnt, a_af); end
    a_wen = 1'b1; a_din = 8'hEE;
    repeat (3) tick();
    a_wen = 1'b0;
    n_assert++; if (a_cnt !== 3'd5) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 5", a_cnt); end
    n_assert++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", a_ovf); end
    for (int i = 0; i < 5; i++) begin
      exp = 8'((i + 1) * 8'h11);
      n_assert++; if (a_dout !== exp) begin n_fail++; $display("FAIL drain_order[%0d] got %h exp %h", i, a_dout, exp); end
      a_read();
    end
    n_assert++; if (a_empty !== 1'b1 || a_cnt !== 3'd0 || a_ae !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b/%0d/%b exp 1/0/1", a_empty, a_cnt, a_ae); end
    n_assert++; if (a_udf !== 1'b0) begin n_fail++; $display("FAIL drain_udf got %b exp 0", a_udf); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) a_write(8'hA1 + 8'(i), 1'b0);
    a_wen = 1'b1; a_ren = 1'b1; a_din = 8'hEE;
    tick();
    a_wen = 1'b0; a_ren = 1'b0;
    n_assert++; if (a_cnt !== 3'd4 || a_full !== 1'b0) begin n_fail++; $display("FAIL simul_full got %0d/%b exp 4/0", a_cnt, a_full); end
    for (int i = 1; i < 5; i++) begin
      exp = 8'hA1 + 8'(i);
      n_assert++; if (a_dout !== exp) begin n_fail++; $display("FAIL simul_order[%0d] got %h exp %h", i, a_dout, exp); end
      a_read();
    end
    n_assert++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL simul_no_overwrite got empty=%b exp 1", a_empty); end
    a_wen = 1'b1; a_ren = 1'b1; a_din = 8'h77;
    tick();
    n_assert++; if (a_cnt !== 3'd1 || a_dout !== 8'h77) begin n_fail++; $display("FAIL simul_empty got %0d/%h exp 1/77", a_cnt, a_dout); end
    n_assert++; if (a_udf !== 1'b0) begin n_fail++; $display("FAIL simul_empty_udf got %b exp 0", a_udf); end
    a_din = 8'h78;
    tick();
    a_wen = 1'b0; a_ren = 1'b0;
    n_assert++; if (a_cnt !== 3'd1 || a_dout !== 8'h78) begin n_fail++; $display("FAIL bypass got %0d/%h exp 1/78", a_cnt, a_dout); end
    tick();
    n_assert++; if (a_dout !== 8'h78) begin n_fail++; $display("FAIL fwft_hold got %h exp 78", a_dout); end
    a_read();
    n_assert++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL simul_final_empty got %b exp 1", a_empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_thresholds();
    a_write(8'h01, 1'b0);
    n_assert++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin n_fail++; $display("FAIL th_cnt1 got ae=%b af=%b exp 1/0", a_ae, a_af); end
    a_write(8'h02, 1'b0);
    n_assert++; if (a_ae !== 1'b0 || a_af !== 1'b0) begin n_fail++; $display("FAIL th_cnt2 got ae=%b af=%b exp 0/0", a_ae, a_af); end
    a_write(8'h03, 1'b0);
    n_assert++; if (a_af !== 1'b1) begin n_fail++; $display("FAIL th_cnt3 got af=%b exp 1", a_af); end
    a_af_th = 3'd4;
    tick();
    n_assert++; if (a_af !== 1'b0 || a_cnt !== 3'd3) begin n_fail++; $display("FAIL th_change got af=%b cnt=%0d exp 0/3", a_af, a_cnt); end
    a_af_th = 3'd3;
    tick();
    n_assert++; if (a_af !== 1'b1) begin n_fail++; $display("FAIL th_restore got af=%b exp 1", a_af); end
    repeat (3) a_read();
    n_assert++; if (a_ae !== 1'b1 || a_empty !== 1'b1) begin n_fail++; $display("FAIL th_drain got ae=%b empty=%b exp 1/1", a_ae, a_empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_packets();
    for (int i = 0; i < 7; i++) b_write(8'hB1 + 8'(i), (i == 2 || i == 6));
    n_assert++; if (b_pkt !== 4'd2 || b_avail !== 1'b1) begin n_fail++; $display("FAIL pkt_count got %0d/%b exp 2/1", b_pkt, b_avail); end
    n_assert++; if (b_cnt !== 4'd7 || b_af !== 1'b1 || b_full !== 1'b0) begin n_fail++; $display("FAIL pkt_fill got %0d/%b/%b exp 7/1/0", b_cnt, b_af, b_full); end
    b_read();
    n_assert++; if (b_dout !== 8'hB1 || b_dout_last !== 1'b0) begin n_fail++; $display("FAIL pkt_rd1 got %h/%b exp B1/0", b_dout, b_dout_last); end
    b_read();
    b_read();
    n_assert++; if (b_dout !== 8'hB3 || b_dout_last !== 1'b1) begin n_fail++; $display("FAIL pkt_rd3 got %h/%b exp B3/1", b_dout, b_dout_last); end
    n_assert++; if (b_pkt !== 4'd1 || b_avail !== 1'b1) begin n_fail++; $display("FAIL pkt_after3 got %0d/%b exp 1/1", b_pkt, b_avail); end
    repeat (4) b_read();
    n_assert++; if (b_dout !== 8'hB7 || b_dout_last !== 1'b1) begin n_fail++; $display("FAIL pkt_rd7 got %h/%b exp B7/1", b_dout, b_dout_last); end
    n_assert++; if (b_pkt !== 4'd0 || b_avail !== 1'b0 || b_empty !== 1'b1) begin n_fail++; $display("FAIL pkt_end got %0d/%b/%b exp 0/0/1", b_pkt, b_avail, b_empty); end
    a_write(8'h5C, 1'b1);
    n_assert++; if (a_dout_last !== 1'b1 || a_pkt !== 3'd1 || a_avail !== 1'b1) begin n_fail++; $display("FAIL pkt_fwft got %b/%0d/%b exp 1/1/1", a_dout_last, a_pkt, a_avail); end
    a_read();
    n_assert++; if (a_pkt !== 3'd0 || a_avail !== 1'b0) begin n_fail++; $display("FAIL pkt_fwft_rd got %0d/%b exp 0/0", a_pkt, a_avail); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_flush();
    for (int i = 0; i < 4; i++) a_write(8'h41 + 8'(i), (i == 1));
    n_assert++; if (a_ovf !== 1'b1 || a_pkt !== 3'd1) begin n_fail++; $display("FAIL flush_pre got ovf=%b pkt=%0d exp 1/1", a_ovf, a_pkt); end
    a_flush = 1'b1; a_wen = 1'b1; a_din = 8'h99;
    tick();
    a_flush = 1'b0; a_wen = 1'b0;
    n_assert++; if (a_cnt !== 3'd0 || a_empty !== 1'b1 || a_empty_n !== 1'b0) begin n_fail++; $display("FAIL flush_cnt got %0d/%b/%b exp 0/1/0", a_cnt, a_empty, a_empty_n); end
    n_assert++; if (a_pkt !== 3'd0 || a_ae !== 1'b1 || a_af !== 1'b0) begin n_fail++; $display("FAIL flush_flags got %0d/%b/%b exp 0/1/0", a_pkt, a_ae, a_af); end
    n_assert++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL flush_ovf_keep got %b exp 1", a_ovf); end
    n_assert++; if (a_dout !== 8'h41) begin n_fail++; $display("FAIL flush_dout_hold got %h exp 41", a_dout); end
    a_write(8'h5A, 1'b0);
    n_assert++; if (a_dout !== 8'h5A || a_cnt !== 3'd1) begin n_fail++; $display("FAIL flush_not_stored got %h/%0d exp 5A/1", a_dout, a_cnt); end
    a_read();
    for (int i = 0; i < 5; i++) a_write(8'h61 + 8'(i), 1'b0);
    n_assert++; if (a_full_n !== 1'b0) begin n_fail++; $display("FAIL flush_full_pre got %b exp 0", a_full_n); end
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    n_assert++; if (a_full_n !== 1'b1 || a_full !== 1'b0) begin n_fail++; $display("FAIL flush_full_release got %b/%b exp 1/0", a_full_n, a_full); end
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    n_assert++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL err_clr_ovf got %b exp 0", a_ovf); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_underflow();
    a_read();
    n_assert++; if (a_udf !== 1'b1 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL udf_set got %b/%0d exp 1/0", a_udf, a_cnt); end
    a_ren = 1'b1; a_err_clr = 1'b1;
    tick();
    a_ren = 1'b0;
    n_assert++; if (a_udf !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins got %b exp 1", a_udf); end
    tick();
    a_err_clr = 1'b0;
    n_assert++; if (a_udf !== 1'b0 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %b/%b exp 0/0", a_udf, a_ovf); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_std_mode();
    b_write(8'hCA, 1'b0);
    b_write(8'hCB, 1'b0);
    n_assert++; if (b_dout !== 8'hB7 || b_empty_n !== 1'b1) begin n_fail++; $display("FAIL std_no_fall got %h/%b exp B7/1", b_dout, b_empty_n); end
    b_read();
    n_assert++; if (b_dout !== 8'hCA) begin n_fail++; $display("FAIL std_rd1 got %h exp CA", b_dout); end
    tick();
    n_assert++; if (b_dout !== 8'hCA) begin n_fail++; $display("FAIL std_hold got %h exp CA", b_dout); end
    b_read();
    n_assert++; if (b_dout !== 8'hCB || b_empty !== 1'b1) begin n_fail++; $display("FAIL std_rd2 got %h/%b exp CB/1", b_dout, b_empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    a_write(8'hD1, 1'b1);
    a_write(8'hD2, 1'b0);
    b_write(8'hE1, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_assert++; if (a_cnt !== 3'd0 || a_empty !== 1'b1 || a_pkt !== 3'd0) begin n_fail++; $display("FAIL rst_mid_a got %0d/%b/%0d exp 0/1/0", a_cnt, a_empty, a_pkt); end
    n_assert++; if (a_dout !== 8'h00 || b_cnt !== 4'd0 || b_ae !== 1'b1) begin n_fail++; $display("FAIL rst_mid_b got %h/%0d/%b exp 00/0/1", a_dout, b_cnt, b_ae); end
    tick();
    rst = 1'b0;
    tick();
    a_write(8'hF0, 1'b0);
    n_assert++; if (a_dout !== 8'hF0 || a_cnt !== 3'd1) begin n_fail++; $display("FAIL rst_mid_discard got %h/%0d exp F0/1", a_dout, a_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_simultaneous();
    test_thresholds();
    test_packets();
    test_flush();
    test_underflow();
    test_std_mode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
